// File: rtl/flip_engine_pkg.sv
// -----------------------------------------------------------------------------
// flip_engine_pkg
// Shared definitions for the flip engine: board cell codes, board geometry,
// the eight scan-direction offsets (in scan order), the FSM state type and a
// bounded address-step helper.
// Optional build macro used by the slice: DRY_RUN_EN (see flip_engine.sv).
// -----------------------------------------------------------------------------
package flip_engine_pkg;

    // Board cell codes as stored in the board RAM
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;
    localparam logic [1:0] WALL  = 2'b11;

    // 10x10 board whose outer ring is wall, addressed row*10+col
    localparam int         BOARD_W     = 10;
    localparam int         BOARD_CELLS = 100;
    localparam logic [7:0] LAST_CELL   = 8'(BOARD_CELLS - 1);

    typedef logic signed [7:0] offset_t;

    // Scan order: -11, -10, -9, -1, +1, +9, +10, +11
    localparam offset_t DIR_OFFSETS [8] = '{
        offset_t'(-(BOARD_W + 1)),
        offset_t'(-BOARD_W),
        offset_t'(-(BOARD_W - 1)),
        offset_t'(-1),
        offset_t'(1),
        offset_t'(BOARD_W - 1),
        offset_t'(BOARD_W),
        offset_t'(BOARD_W + 1)
    };

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHK_POS  = 3'd1,
        SCAN     = 3'd2,
        FLIP     = 3'd3,
        NEXT_DIR = 3'd4,
        PLACE    = 3'd5,
        FIN      = 3'd6
    } state_e;

    // Step an address by a direction offset in 8-bit arithmetic. A step that
    // would leave the board (including wrap below zero) holds the address, so
    // speculative look-ahead reads past a wall never escape 0..99.
    function automatic logic [7:0] step_addr(input logic [7:0] base, input offset_t off);
        logic [7:0] sum;
        sum = base + $unsigned(off);
        if (sum <= LAST_CELL) begin
            return sum;
        end else begin
            return base;
        end
    endfunction

endpackage

// File: rtl/flip_engine_if.sv
// -----------------------------------------------------------------------------
// flip_engine_if
// Bundles the move request/result handshake and the board RAM port.
//   start/pos/player      : move request (master -> engine)
//   busy/done/valid/flip_count : status and result (engine -> master)
//   mem_addr/mem_wdata/mem_wren: board RAM request (engine -> RAM)
//   mem_rdata             : board RAM read data, 1-cycle latency (RAM -> engine)
//   dry_run               : present only when DRY_RUN_EN is defined
// -----------------------------------------------------------------------------
interface flip_engine_if;

    logic       start;
    logic [7:0] pos;
    logic [1:0] player;
`ifdef DRY_RUN_EN
    logic       dry_run;
`endif
    logic       busy;
    logic       done;
    logic       valid;
    logic [5:0] flip_count;
    logic [7:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem_wdata;
    logic       mem_wren;

    modport master (
        output start, pos, player, mem_rdata,
`ifdef DRY_RUN_EN
        output dry_run,
`endif
        input  busy, done, valid, flip_count, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  start, pos, player, mem_rdata,
`ifdef DRY_RUN_EN
        input  dry_run,
`endif
        output busy, done, valid, flip_count, mem_addr, mem_wdata, mem_wren
    );

endinterface

// File: rtl/flip_dir_rom.sv
// -----------------------------------------------------------------------------
// flip_dir_rom
// Maps a direction index 0..7 to its signed board-address offset.
//   dir_i    : direction index
//   offset_o : signed 8-bit offset
// -----------------------------------------------------------------------------
module flip_dir_rom
    import flip_engine_pkg::*;
(
    input  logic [2:0] dir_i,
    output offset_t    offset_o
);

    // Direction table lookup
    always_comb begin
        offset_o = DIR_OFFSETS[dir_i];
    end

endmodule

// File: rtl/flip_engine.sv
// -----------------------------------------------------------------------------
// flip_engine
// Evaluates an Othello-style move against a board held in an external RAM
// (1-cycle read latency): scans the eight directions, flips bracketed
// opponent runs, places the disc and reports legality and flip count.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus    : flip_engine_if.slave (request, status, board RAM port)
// Build option: DRY_RUN_EN adds bus.dry_run (latched at start); when set the
// move is evaluated identically but mem_wren is never raised.
// Scan reads are pipelined: the address one step ahead is presented while the
// current cell's data is being examined, so each scanned cell costs 1 cycle.
// -----------------------------------------------------------------------------
module flip_engine
    import flip_engine_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    flip_engine_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] pos_q, pos_d;
    logic [1:0] player_q, player_d;
    logic [2:0] dir_q, dir_d;
    offset_t    off_q, off_d;
    logic [2:0] run_q, run_d;
    logic       wait_q, wait_d;
    logic [7:0] addr_q, addr_d;
    logic [5:0] flip_count_q, flip_count_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       wren_q, wren_d;
    logic [1:0] wdata_q, wdata_d;
`ifdef DRY_RUN_EN
    logic       dry_q, dry_d;
`endif

    logic [2:0] nxt_dir_s;
    offset_t    nxt_off_s;
    logic [1:0] opp_s;
    logic       wr_state_s;
    logic       wr_inhibit_s;

    // The ROM always looks up the direction after the current one
    assign nxt_dir_s = dir_q + 3'd1;
    assign opp_s     = player_q ^ 2'b11;

    flip_dir_rom u_dir_rom (
        .dir_i    (nxt_dir_s),
        .offset_o (nxt_off_s)
    );

`ifdef DRY_RUN_EN
    assign wr_inhibit_s = dry_d;
`else
    assign wr_inhibit_s = 1'b0;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        player_d     = player_q;
        dir_d        = dir_q;
        off_d        = off_q;
        run_d        = run_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        flip_count_d = flip_count_q;
        valid_d      = valid_q;
`ifdef DRY_RUN_EN
        dry_d        = dry_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pos_d        = bus.pos;
                    player_d     = bus.player;
                    flip_count_d = 6'd0;
                    valid_d      = 1'b0;
                    run_d        = 3'd0;
                    // Parked on the last index so the ROM presents direction 0
                    dir_d        = 3'd7;
`ifdef DRY_RUN_EN
                    dry_d        = bus.dry_run;
`endif
                    if ((bus.player == EMPTY) || (bus.player == WALL) || (bus.pos > LAST_CELL)) begin
                        state_d = FIN;
                    end else begin
                        state_d = CHK_POS;
                        addr_d  = bus.pos;
                        wait_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CHK_POS: begin
                if (wait_q) begin
                    // Read of pos is in flight; pre-issue the first direction-0 cell
                    wait_d = 1'b0;
                    addr_d = step_addr(pos_q, nxt_off_s);
                end else if (bus.mem_rdata != EMPTY) begin
                    state_d = FIN;
                end else begin
                    state_d = SCAN;
                    dir_d   = nxt_dir_s;
                    off_d   = nxt_off_s;
                    run_d   = 3'd0;
                    addr_d  = step_addr(addr_q, nxt_off_s);
                end
            end
            SCAN: begin
                if (bus.mem_rdata == opp_s) begin
                    run_d  = run_q + 3'd1;
                    addr_d = step_addr(addr_q, off_q);
                end else if ((bus.mem_rdata == player_q) && (run_q != 3'd0)) begin
                    state_d = FLIP;
                    addr_d  = step_addr(pos_q, off_q);
                end else begin
                    state_d = NEXT_DIR;
                    addr_d  = step_addr(pos_q, nxt_off_s);
                end
            end
            FLIP: begin
                flip_count_d = flip_count_q + 6'd1;
                valid_d      = 1'b1;
                run_d        = run_q - 3'd1;
                if (run_q == 3'd1) begin
                    state_d = NEXT_DIR;
                    addr_d  = step_addr(pos_q, nxt_off_s);
                end else begin
                    addr_d  = step_addr(addr_q, off_q);
                end
            end
            NEXT_DIR: begin
                // Entered with the next direction's first cell already presented
                if (dir_q == 3'd7) begin
                    if (valid_q) begin
                        state_d = PLACE;
                        addr_d  = pos_q;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    state_d = SCAN;
                    dir_d   = nxt_dir_s;
                    off_d   = nxt_off_s;
                    run_d   = 3'd0;
                    addr_d  = step_addr(addr_q, nxt_off_s);
                end
            end
            PLACE: begin
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are derived from the state being entered
        wr_state_s = (state_d == FLIP) || (state_d == PLACE);
        wren_d     = wr_state_s && !wr_inhibit_s;
        wdata_d    = wr_state_s ? player_d : EMPTY;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pos_q        <= 8'd0;
            player_q     <= 2'b00;
            dir_q        <= 3'd0;
            off_q        <= 8'sd0;
            run_q        <= 3'd0;
            wait_q       <= 1'b0;
            addr_q       <= 8'd0;
            flip_count_q <= 6'd0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wren_q       <= 1'b0;
            wdata_q      <= 2'b00;
`ifdef DRY_RUN_EN
            dry_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            player_q     <= player_d;
            dir_q        <= dir_d;
            off_q        <= off_d;
            run_q        <= run_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            flip_count_q <= flip_count_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wren_q       <= wren_d;
            wdata_q      <= wdata_d;
`ifdef DRY_RUN_EN
            dry_q        <= dry_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.flip_count = flip_count_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wren   = wren_q;

endmodule

// File: tb/tb_flip_engine.sv
// -----------------------------------------------------------------------------
// tb_flip_engine
// Directed bench for flip_engine with a 1-cycle-latency board RAM model.
// Expected RAM writes are queued when a move is issued and matched against
// each observed write. Build with DRY_RUN_EN to include the dry-run case.
// -----------------------------------------------------------------------------
module tb_flip_engine;

    logic clk;
    logic rst_n;

    flip_engine_if bus ();

    flip_engine dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] mem [0:255];
    logic [1:0] img [0:99];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [1:0] tb_data;

    logic [9:0] wq [$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         oor_cnt = 0;
    int         bad_wdata = 0;
    bit         dry_mode = 1'b0;
    int         dirs [8] = '{-11, -10, -9, -1, 1, 9, 10, 11};

    // Board RAM: synchronous read, DUT writes take priority over bench loads
    always @(posedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Write monitor: every DUT write must match the head of the expected queue
    always @(negedge clk) begin
        logic [9:0] exp_w;
        if (bus.mem_wren === 1'b1) begin
            exp_w = (wq.size() != 0) ? wq.pop_front() : 10'h3FF;
            check("mem_write{addr,data}", {bus.mem_addr, bus.mem_wdata}, exp_w);
        end
        if (bus.busy === 1'b1 && bus.mem_addr > 8'd99) oor_cnt++;
        if (bus.mem_wren !== 1'b1 && bus.mem_wdata !== 2'b00 && !dry_mode) bad_wdata++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_img();
        for (int i = 0; i < 100; i++) begin
            img[i] = ((i / 10) == 0 || (i / 10) == 9 || (i % 10) == 0 || (i % 10) == 9) ? 2'b11 : 2'b00;
        end
    endtask

    task automatic load_img();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_addr = 8'(i); tb_data = img[i];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic opening_img();
        clear_img();
        img[44] = 2'b10; img[45] = 2'b01; img[54] = 2'b01; img[55] = 2'b10;
    endtask

    task automatic row1_img();
        clear_img();
        for (int c = 2; c <= 7; c++) img[10 + c] = 2'b10;
        img[18] = 2'b01;
    endtask

    // Reference move evaluation on the current RAM contents
    task automatic ref_move(input int p, input logic [1:0] pl, output int v, output int fc);
        logic [1:0] opp;
        int q, run;
        v = 0; fc = 0;
        if (pl == 2'b00 || pl == 2'b11 || p > 99) return;
        if (mem[p] != 2'b00) return;
        opp = pl ^ 2'b11;
        for (int d = 0; d < 8; d++) begin
            run = 0;
            q = p + dirs[d];
            while (q >= 0 && q <= 99 && mem[q] == opp) begin
                run++;
                q += dirs[d];
            end
            if (q >= 0 && q <= 99 && mem[q] == pl && run > 0) begin
                for (int k = 1; k <= run; k++) wq.push_back({8'(p + k * dirs[d]), pl});
                fc += run;
                v = 1;
            end
        end
        if (v == 1) wq.push_back({8'(p), pl});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_flip_count"}, bus.flip_count, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wren"}, bus.mem_wren, 0);
    endtask

    task automatic do_move(input string tag, input logic [7:0] p, input logic [1:0] pl, input bit dry,
                           input int ev, input int efc, input int max_lat, input bit poke);
        int lat;
        bit seen;
        @(negedge clk);
        dry_mode   = dry;
        bus.start  = 1'b1;
        bus.pos    = p;
        bus.player = pl;
`ifdef DRY_RUN_EN
        bus.dry_run = dry;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        seen = bus.done;
        while (!seen && lat < 200) begin
            if (poke && lat == 4) begin
                bus.start = 1'b1; bus.pos = 8'd34; bus.player = 2'b10;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency_within_bound"}, (lat <= max_lat), 1);
        check({tag, "_valid"}, bus.valid, ev);
        check({tag, "_flip_count"}, bus.flip_count, efc);
        check({tag, "_pending_writes"}, wq.size(), 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, bus.done, 0);
        check({tag, "_busy_cleared"}, bus.busy, 0);
        check({tag, "_valid_held"}, bus.valid, ev);
        dry_mode = 1'b0;
    endtask

    initial begin
        int v, fc, cnt;
        logic [7:0] p;
        logic [1:0] pl;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.pos = 8'd0; bus.player = 2'b00;
`ifdef DRY_RUN_EN
        bus.dry_run = 1'b0;
`endif
        tb_we = 1'b0; tb_addr = 8'd0; tb_data = 2'b00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Opening board: one flip to the east, then place
        opening_img(); load_img();
        wq.push_back({8'd44, 2'b01}); wq.push_back({8'd43, 2'b01});
        do_move("open_43_black", 8'd43, 2'b01, 1'b0, 1, 1, 116, 1'b0);
        check("open_43_cell44", mem[44], 2'b01);
        check("open_43_cell43", mem[43], 2'b01);

        // Occupied target rejected quickly
        opening_img(); load_img();
        do_move("occupied_44", 8'd44, 2'b01, 1'b0, 0, 0, 3, 1'b0);

        // Corner cell with nothing to bracket
        do_move("corner_11_white", 8'd11, 2'b10, 1'b0, 0, 0, 116, 1'b0);

        // Illegal player codes and out-of-range position
        do_move("player_00", 8'd43, 2'b00, 1'b0, 0, 0, 2, 1'b0);
        do_move("player_11", 8'd43, 2'b11, 1'b0, 0, 0, 2, 1'b0);
        do_move("pos_150", 8'd150, 2'b01, 1'b0, 0, 0, 2, 1'b0);

        // Six-long run along row 1, with a start pulse while busy
        row1_img(); load_img();
        for (int c = 2; c <= 7; c++) wq.push_back({8'(10 + c), 2'b01});
        wq.push_back({8'd11, 2'b01});
        do_move("row1_run6", 8'd11, 2'b01, 1'b0, 1, 6, 116, 1'b1);
        check("row1_cell17", mem[17], 2'b01);

        // Reset two writes into the flip sequence
        row1_img(); load_img();
        wq.push_back({8'd12, 2'b01}); wq.push_back({8'd13, 2'b01});
        @(negedge clk);
        bus.start = 1'b1; bus.pos = 8'd11; bus.player = 2'b01;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.mem_wren !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_flip_started", bus.mem_wren, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid_flip");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_partial_12", mem[12], 2'b01);
        check("rst_partial_13", mem[13], 2'b01);
        check("rst_untouched_14", mem[14], 2'b10);
        check("rst_pending_writes", wq.size(), 0);

        // All eight directions bracket at once
        clear_img();
        img[44] = 2'b10; img[45] = 2'b10; img[46] = 2'b10; img[54] = 2'b10;
        img[56] = 2'b10; img[64] = 2'b10; img[65] = 2'b10; img[66] = 2'b10;
        img[33] = 2'b01; img[35] = 2'b01; img[37] = 2'b01; img[53] = 2'b01;
        img[57] = 2'b01; img[73] = 2'b01; img[75] = 2'b01; img[77] = 2'b01;
        load_img();
        ref_move(55, 2'b01, v, fc);
        do_move("star_55", 8'd55, 2'b01, 1'b0, 1, 8, 116, 1'b0);

`ifdef DRY_RUN_EN
        // Dry run: same answer, RAM untouched
        opening_img(); load_img();
        do_move("dry_43", 8'd43, 2'b01, 1'b1, 1, 1, 116, 1'b0);
        check("dry_cell44", mem[44], 2'b10);
        check("dry_cell43", mem[43], 2'b00);
`endif

        // Random boards checked against the reference evaluation
        for (int r = 0; r < 8; r++) begin
            clear_img();
            for (int i = 11; i <= 88; i++) begin
                if (img[i] != 2'b11) img[i] = 2'($urandom_range(0, 2));
            end
            p = 8'($urandom_range(11, 88));
            if (img[p] != 2'b11) img[p] = 2'b00;
            pl = 2'($urandom_range(1, 2));
            load_img();
            ref_move(int'(p), pl, v, fc);
            do_move("random", p, pl, 1'b0, v, fc, 116, 1'b0);
        end

        check("addr_out_of_range_cycles", oor_cnt, 0);
        check("wdata_nonzero_idle_cycles", bad_wdata, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/flip_engine.md
FLIP_ENGINE -- requirements
Module: flip_engine

Interface
REQ-001 clock  input  1  rising-edge system clock.
REQ-002 reset  input  1  asynchronous, active-low reset; the block is in reset while low.
REQ-003 start  input  1  one-cycle move request; sampled only in IDLE.
REQ-004 pos  input  8  board address of the move, row*10+col on the 10x10 bordered board (0..99).
REQ-005 player  input  2  mover colour: 01 black, 10 white.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse when evaluation ends.
REQ-008 valid  output  1  move legal; held from done until the next accepted start.
REQ-009 flip_count  output  6  total discs flipped; held like valid.
REQ-010 mem_addr  output  8  board RAM address.
REQ-011 mem_rdata  input  2  board RAM read data; cell codes 00 empty, 01 black, 10 white, 11 wall.
REQ-012 mem_wdata  output  2  board RAM write data.
REQ-013 mem_wren  output  1  board RAM write enable.

Function
REQ-014 RAM read latency SHALL be exactly 1 cycle: mem_rdata for mem_addr driven in cycle N is sampled in cycle N+1.
REQ-015 FSM states SHALL be IDLE, CHK_POS, SCAN, FLIP, NEXT_DIR, PLACE and FIN.
REQ-016 IDLE + start: latch pos and player, clear flip_count and valid, then go to CHK_POS.
REQ-017 The move SHALL be rejected immediately, going to FIN with valid=0, if player is 00 or 11 or pos > 99.
REQ-018 CHK_POS: if the cell at pos is not 00, go to FIN with valid=0.
REQ-019 Directions SHALL be scanned in fixed order: -11, -10, -9, -1, +1, +9, +10, +11.
REQ-020 SCAN steps from pos+offset; each opponent cell increments a 3-bit run counter and advances.
REQ-021 SCAN on an own-colour cell with run>0 SHALL go to FLIP; on own with run=0, empty, or wall it SHALL go to NEXT_DIR.
REQ-022 FLIP rewalks from pos+offset, writing player to run cells at one write per cycle, adds run to flip_count, and sets valid=1.
REQ-023 The wall ring SHALL bound every walk; address arithmetic SHALL be 8-bit and never leave 0..99.
REQ-024 After the 8th direction, go to PLACE if valid=1, else to FIN.
REQ-025 PLACE SHALL write player at pos in one cycle.
REQ-026 FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-027 mem_wren SHALL be high only in FLIP and PLACE; mem_wdata SHALL equal player in those states and 00 otherwise.
REQ-028 start while busy SHALL be ignored.
REQ-029 Start to done latency SHALL be at most 2 + 8*(2+2*6) + 2 = 116 cycles.

Reset
REQ-030 Reset low SHALL force IDLE and drive busy=0, done=0, valid=0, flip_count=0, mem_addr=0, mem_wdata=00, mem_wren=0.
REQ-031 Reset mid-FLIP SHALL abort with no further writes; partial flips remain in RAM.

Configuration
REQ-032 With DRY_RUN_EN defined, an input dry_run (1 bit, latched at start) SHALL be added; when it is 1, mem_wren SHALL stay 0 while valid and flip_count are computed identically.
REQ-033 With DRY_RUN_EN undefined, the dry_run port SHALL be absent and writes SHALL always occur.

Structure
REQ-034 The shared package SHALL hold the cell codes (EMPTY, BLACK, WHITE, WALL), BOARD_W=10, BOARD_CELLS=100, the direction offset table, and the FSM state enum.
REQ-035 One sub-module, flip_dir_rom, SHALL map direction index 0..7 to its signed offset.

Verification
REQ-036 Preload 44=10, 45=01, 54=01, 55=10, all else empty or wall; move pos=43, player=01 -> valid=1, flip_count=1, writes 44<=01 then 43<=01.
REQ-037 Same board; move pos=44, player=01 -> done within 3 cycles, valid=0, no mem_wren.
REQ-038 Same board; move pos=11, player=10 -> valid=0, flip_count=0, no writes.
REQ-039 Row 1 set to 11=empty, 12..17=10, 18=01; move pos=11, player=01 -> flip_count=6, all 6 cells written 01.
REQ-040 Reset pulsed 2 cycles into FLIP in REQ-039 -> all outputs zero next cycle, no further mem_wren.
REQ-041 With DRY_RUN_EN defined and dry_run=1, the REQ-036 move -> valid=1, flip_count=1, mem_wren never high.
